// File: rtl/game_pkg.sv
// Shared phase encoding, pipe command codes and countdown start value for the game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        OVER      = 3'd4
    } game_state_t;

    localparam logic [1:0] PIPE_NONE       = 2'b00;
    localparam logic [1:0] PIPE_UP         = 2'b01;
    localparam logic [1:0] PIPE_DOWN       = 2'b10;
    localparam logic [1:0] COUNTDOWN_START = 2'd3;

    // Opposing pipe buttons cancel each other out.
    function automatic logic [1:0] pipe_sel(input logic up, input logic down);
        if (up && !down) return PIPE_UP;
        if (down && !up) return PIPE_DOWN;
        return PIPE_NONE;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control bundle between the game sequencer (master) and the game datapath / player inputs (slave).
interface game_sequencer_if #(parameter int SCORE_W = 16);
    import game_pkg::*;

    logic               tick;
    logic               btn_start;
    logic               btn_fly;
    logic               btn_pipe_up;
    logic               btn_pipe_down;
    logic               fail;
    logic [SCORE_W-1:0] score;

    game_state_t        state;
    logic               dp_clear;
    logic               frame_en;
    logic               fly_req;
    logic [1:0]         pipe_cmd;
    logic [1:0]         countdown;
    logic [SCORE_W-1:0] hi_score;
    logic               new_record;

    modport master (
        input  tick, btn_start, btn_fly, btn_pipe_up, btn_pipe_down, fail, score,
        output state, dp_clear, frame_en, fly_req, pipe_cmd, countdown, hi_score, new_record
    );

    modport slave (
        output tick, btn_start, btn_fly, btn_pipe_up, btn_pipe_down, fail, score,
        input  state, dp_clear, frame_en, fly_req, pipe_cmd, countdown, hi_score, new_record
    );

endinterface

// File: rtl/game_sequencer_edge_det.sv
// Rising-edge detector on a registered button level; a held button yields a single edge.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic now_q, prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            now_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            now_q  <= level;
            prev_q <= now_q;
        end
    end

    assign rise = now_q & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Game phase sequencer: start/countdown/play/pause/over control and frame pacing for the datapath.
// Define GAME_SEQ_HISCORE_EN to build the high-score register and new_record pulse.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICKS_PER_COUNT = 10,
    parameter int SCORE_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    game_sequencer_if.master bus
);

    localparam int NUM_BTN = 4;
    localparam int CNT_W   = (TICKS_PER_COUNT > 1) ? $clog2(TICKS_PER_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_COUNT - 1);

    logic [NUM_BTN-1:0] btn_lvl, btn_rise;
    logic               start_rise, fly_rise;
    logic [1:0]         unused_pipe_rise;

    assign btn_lvl = {bus.btn_pipe_down, bus.btn_pipe_up, bus.btn_fly, bus.btn_start};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        edge_det u_edge (.clk(clk), .rst(rst), .level(btn_lvl[i]), .rise(btn_rise[i]));
    end

    assign start_rise       = btn_rise[0];
    assign fly_rise         = btn_rise[1];
    // Pipe commands follow levels, so their edges are not consumed.
    assign unused_pipe_rise = btn_rise[3:2];

    game_state_t      state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [1:0]       cd_q, cd_n;
    logic [1:0]       pipe_cmd_q, pipe_cmd_n;
    logic             dp_clear_q, dp_clear_n;
    logic             frame_en_q, frame_en_n;
    logic             fly_req_q, fly_req_n;
    logic             fly_lat_q, fly_lat_n;
    logic             over_entry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cd_q       <= '0;
            pipe_cmd_q <= PIPE_NONE;
            dp_clear_q <= 1'b0;
            frame_en_q <= 1'b0;
            fly_req_q  <= 1'b0;
            fly_lat_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            cd_q       <= cd_n;
            pipe_cmd_q <= pipe_cmd_n;
            dp_clear_q <= dp_clear_n;
            frame_en_q <= frame_en_n;
            fly_req_q  <= fly_req_n;
            fly_lat_q  <= fly_lat_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        cd_n       = cd_q;
        pipe_cmd_n = PIPE_NONE;
        dp_clear_n = 1'b0;
        frame_en_n = 1'b0;
        fly_req_n  = 1'b0;
        fly_lat_n  = fly_lat_q | fly_rise;
        over_entry = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                fly_lat_n = 1'b0;
                if (start_rise) begin
                    state_n    = COUNTDOWN;
                    cd_n       = COUNTDOWN_START;
                    cnt_n      = '0;
                    dp_clear_n = 1'b1;
                end
            end
            COUNTDOWN: begin
                fly_lat_n = 1'b0;
                if (bus.tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_n = '0;
                        if (cd_q == 2'd1) begin
                            state_n = PLAY;
                            cd_n    = 2'd0;
                        end else begin
                            cd_n = cd_q - 2'd1;
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            PLAY: begin
                // Collision outranks pause and the frame of the same cycle.
                if (bus.fail) begin
                    state_n    = OVER;
                    fly_lat_n  = 1'b0;
                    over_entry = 1'b1;
                end else if (start_rise) begin
                    state_n   = PAUSE;
                    fly_lat_n = 1'b0;
                end else if (bus.tick) begin
                    frame_en_n = 1'b1;
                    fly_req_n  = fly_lat_q | fly_rise;
                    fly_lat_n  = 1'b0;
                    pipe_cmd_n = pipe_sel(bus.btn_pipe_up, bus.btn_pipe_down);
                end
            end
            PAUSE: begin
                fly_lat_n = 1'b0;
                if (start_rise) state_n = PLAY;
            end
            default: begin
                state_n   = IDLE;
                fly_lat_n = 1'b0;
            end
        endcase
    end

    assign bus.state     = state_q;
    assign bus.dp_clear  = dp_clear_q;
    assign bus.frame_en  = frame_en_q;
    assign bus.fly_req   = fly_req_q;
    assign bus.pipe_cmd  = pipe_cmd_q;
    assign bus.countdown = cd_q;

`ifdef GAME_SEQ_HISCORE_EN
    logic [SCORE_W-1:0] hi_q;
    logic               rec_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q  <= '0;
            rec_q <= 1'b0;
        end else begin
            rec_q <= 1'b0;
            if (over_entry && (bus.score > hi_q)) begin
                hi_q  <= bus.score;
                rec_q <= 1'b1;
            end
        end
    end

    assign bus.hi_score   = hi_q;
    assign bus.new_record = rec_q;
`else
    logic [SCORE_W-1:0] unused_score;
    logic               unused_over_entry;

    assign unused_score      = bus.score;
    assign unused_over_entry = over_entry;
    assign bus.hi_score      = '0;
    assign bus.new_record    = 1'b0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized self-checking bench for game_sequencer against a frame-level reference model.
module tb_game_sequencer;
    import game_pkg::*;

    localparam int TPC = 2;
    localparam int SW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    game_sequencer_if #(.SCORE_W(SW)) bus();
    game_sequencer #(.TICKS_PER_COUNT(TPC), .SCORE_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0, bad = 0;
    int frames = 0, clears = 0, records = 0;
    logic       got_fly[$];
    logic [1:0] got_pipe[$];
    logic [SW-1:0] hi_exp = '0;

    always @(negedge clk) begin
        if (bus.frame_en === 1'b1) begin
            frames++;
            got_fly.push_back(bus.fly_req);
            got_pipe.push_back(bus.pipe_cmd);
        end
        if (bus.dp_clear === 1'b1)   clears++;
        if (bus.new_record === 1'b1) records++;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press_start();
        bus.btn_start = 1'b1; cyc(1); bus.btn_start = 1'b0; cyc(2);
    endtask

    task automatic press_fly();
        bus.btn_fly = 1'b1; cyc(1); bus.btn_fly = 1'b0; cyc(2);
    endtask

    task automatic do_tick();
        bus.tick = 1'b1; cyc(1); bus.tick = 1'b0; cyc(1);
    endtask

    task automatic test_reset();
        rst = 1'b0; cyc(2);
        total++; if (bus.state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, IDLE); end
        total++; if (bus.countdown !== 2'd0) begin bad++; $display("FAIL reset_countdown got=%0d exp=0", bus.countdown); end
        total++; if ({bus.dp_clear, bus.frame_en, bus.fly_req, bus.new_record} !== 4'b0) begin bad++;
            $display("FAIL reset_pulses got=%b exp=0000", {bus.dp_clear, bus.frame_en, bus.fly_req, bus.new_record}); end
        total++; if (bus.pipe_cmd !== PIPE_NONE) begin bad++; $display("FAIL reset_pipe got=%0d exp=0", bus.pipe_cmd); end
        total++; if (bus.hi_score !== '0) begin bad++; $display("FAIL reset_hi got=%0d exp=0", bus.hi_score); end
        rst = 1'b1; cyc(2);
        repeat (3) do_tick();
        total++; if (frames !== 0 || bus.state !== IDLE) begin bad++;
            $display("FAIL idle_ticks frames=%0d state=%0d exp 0/%0d", frames, bus.state, IDLE); end
    endtask

    task automatic test_countdown();
        int c0, f0, exp_cd;
        c0 = clears; f0 = frames;
        press_start();
        total++; if (clears - c0 !== 1) begin bad++; $display("FAIL start_clear got=%0d exp=1", clears - c0); end
        total++; if (bus.state !== COUNTDOWN || bus.countdown !== 2'd3) begin bad++;
            $display("FAIL start_cd state=%0d cd=%0d exp %0d/3", bus.state, bus.countdown, COUNTDOWN); end
        for (int k = 1; k <= 3 * TPC; k++) begin
            do_tick();
            if (k < 3 * TPC) begin
                exp_cd = 3 - k / TPC;
                total++; if (bus.state !== COUNTDOWN || bus.countdown !== exp_cd[1:0]) begin bad++;
                    $display("FAIL cd_tick%0d state=%0d cd=%0d exp %0d/%0d", k, bus.state, bus.countdown, COUNTDOWN, exp_cd); end
            end else begin
                total++; if (bus.state !== PLAY || bus.countdown !== 2'd0) begin bad++;
                    $display("FAIL cd_play state=%0d cd=%0d exp %0d/0", bus.state, bus.countdown, PLAY); end
            end
        end
        total++; if (frames !== f0 || clears - c0 !== 1) begin bad++;
            $display("FAIL cd_quiet frames=%0d clears=%0d exp %0d/1", frames - f0, clears - c0, 0); end
    endtask

    task automatic test_fly();
        logic exp_fly[$];
        got_fly.delete(); got_pipe.delete();
        press_fly();
        do_tick(); do_tick();
        exp_fly.push_back(1'b1); exp_fly.push_back(1'b0);
        bus.btn_fly = 1'b1; cyc(2);
        repeat (5) do_tick();
        bus.btn_fly = 1'b0; cyc(2);
        exp_fly.push_back(1'b1);
        repeat (4) exp_fly.push_back(1'b0);
        total++; if (got_fly.size() !== exp_fly.size()) begin bad++;
            $display("FAIL fly_frames got=%0d exp=%0d", got_fly.size(), exp_fly.size()); end
        else for (int i = 0; i < exp_fly.size(); i++) begin
            total++; if (got_fly[i] !== exp_fly[i]) begin bad++;
                $display("FAIL fly_req_f%0d got=%b exp=%b", i, got_fly[i], exp_fly[i]); end
        end
    endtask

    task automatic test_pipe_random();
        logic       exp_fly[$];
        logic [1:0] exp_pipe[$];
        logic up, dn;
        int nfly;
        got_fly.delete(); got_pipe.delete();
        for (int i = 0; i < 24; i++) begin
            if (i < 3) begin up = (i != 2); dn = (i != 1); end
            else begin up = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1)); end
            nfly = $urandom_range(0, 2);
            repeat (nfly) press_fly();
            bus.btn_pipe_up = up; bus.btn_pipe_down = dn;
            do_tick();
            exp_fly.push_back(nfly > 0);
            exp_pipe.push_back((up && !dn) ? 2'd1 : (dn && !up) ? 2'd2 : 2'd0);
        end
        bus.btn_pipe_up = 1'b0; bus.btn_pipe_down = 1'b0;
        total++; if (got_pipe.size() !== exp_pipe.size()) begin bad++;
            $display("FAIL pipe_frames got=%0d exp=%0d", got_pipe.size(), exp_pipe.size()); end
        else for (int i = 0; i < exp_pipe.size(); i++) begin
            total++; if (got_pipe[i] !== exp_pipe[i] || got_fly[i] !== exp_fly[i]) begin bad++;
                $display("FAIL frame%0d pipe=%0d fly=%b exp %0d/%b", i, got_pipe[i], got_fly[i], exp_pipe[i], exp_fly[i]); end
        end
    endtask

    task automatic test_pause();
        int f0;
        press_start();
        total++; if (bus.state !== PAUSE) begin bad++; $display("FAIL pause_enter got=%0d exp=%0d", bus.state, PAUSE); end
        f0 = frames;
        press_fly();
        repeat (3) do_tick();
        bus.fail = 1'b1; cyc(2); bus.fail = 1'b0; cyc(1);
        total++; if (bus.state !== PAUSE || frames !== f0) begin bad++;
            $display("FAIL pause_hold state=%0d frames=%0d exp %0d/0", bus.state, frames - f0, PAUSE); end
        press_start();
        total++; if (bus.state !== PLAY) begin bad++; $display("FAIL pause_resume got=%0d exp=%0d", bus.state, PLAY); end
        got_fly.delete(); got_pipe.delete();
        do_tick();
        total++; if (frames !== f0 + 1 || got_fly.size() != 1 || got_fly[0] !== 1'b0) begin bad++;
            $display("FAIL pause_frame frames=%0d fly=%b exp 1/0", frames - f0, (got_fly.size() > 0) ? got_fly[0] : 1'bx); end
    endtask

    task automatic test_over();
        logic [SW-1:0] scores[4];
        int r0, f0, exp_rec;
        scores[0] = 16'd7; scores[1] = 16'd7;
        scores[2] = SW'($urandom_range(8, 1000)); scores[3] = SW'($urandom_range(0, 6));
        for (int g = 0; g < 4; g++) begin
            if (g > 0) begin
                press_start();
                repeat (3 * TPC) do_tick();
                total++; if (bus.state !== PLAY) begin bad++; $display("FAIL game%0d_play got=%0d exp=%0d", g, bus.state, PLAY); end
            end
            bus.score = scores[g];
            r0 = records;
            // The detector registers the level, so the edge reaches the FSM one cycle after the button.
            bus.btn_start = 1'b1; cyc(1);
            bus.btn_start = 1'b0; bus.fail = 1'b1; cyc(1);
            bus.fail = 1'b0; cyc(1);
            exp_rec = 0;
`ifdef GAME_SEQ_HISCORE_EN
            if (scores[g] > hi_exp) begin hi_exp = scores[g]; exp_rec = 1; end
`endif
            total++; if (bus.state !== OVER) begin bad++; $display("FAIL game%0d_over got=%0d exp=%0d", g, bus.state, OVER); end
            total++; if (bus.hi_score !== hi_exp) begin bad++; $display("FAIL game%0d_hi got=%0d exp=%0d", g, bus.hi_score, hi_exp); end
            total++; if (records - r0 !== exp_rec) begin bad++; $display("FAIL game%0d_record got=%0d exp=%0d", g, records - r0, exp_rec); end
            f0 = frames;
            do_tick(); do_tick();
            total++; if (frames !== f0 || bus.state !== OVER) begin bad++;
                $display("FAIL game%0d_over_ticks frames=%0d state=%0d", g, frames - f0, bus.state); end
        end
    endtask

    task automatic test_reset_mid();
        int f0, c0;
        press_start();
        repeat (TPC) do_tick();
        total++; if (bus.countdown !== 2'd2) begin bad++; $display("FAIL mid_cd got=%0d exp=2", bus.countdown); end
        f0 = frames;
        #2 rst = 1'b0; #1;
        hi_exp = '0;
        total++; if (bus.state !== IDLE || bus.countdown !== 2'd0) begin bad++;
            $display("FAIL async_reset state=%0d cd=%0d exp %0d/0", bus.state, bus.countdown, IDLE); end
        total++; if ({bus.dp_clear, bus.frame_en, bus.fly_req, bus.new_record, bus.pipe_cmd} !== 6'b0 || bus.hi_score !== '0) begin bad++;
            $display("FAIL async_reset_outs got=%b hi=%0d exp 0", {bus.dp_clear, bus.frame_en, bus.fly_req, bus.new_record, bus.pipe_cmd}, bus.hi_score); end
        cyc(2); rst = 1'b1; cyc(2);
        repeat (4) do_tick();
        total++; if (frames !== f0 || bus.state !== IDLE) begin bad++;
            $display("FAIL post_reset_quiet frames=%0d state=%0d", frames - f0, bus.state); end
        c0 = clears;
        press_start();
        total++; if (bus.state !== COUNTDOWN || bus.countdown !== 2'd3 || clears - c0 !== 1) begin bad++;
            $display("FAIL post_reset_start state=%0d cd=%0d clears=%0d", bus.state, bus.countdown, clears - c0); end
        repeat (3 * TPC) do_tick();
        do_tick();
        total++; if (frames !== f0 + 1) begin bad++; $display("FAIL post_reset_play frames=%0d exp=1", frames - f0); end
        // Reset in PLAY: ticks while held must not produce frames.
        rst = 1'b0; cyc(1);
        repeat (2) do_tick();
        rst = 1'b1; cyc(1);
        do_tick();
        total++; if (frames !== f0 + 1 || bus.state !== IDLE) begin bad++;
            $display("FAIL play_reset frames=%0d state=%0d", frames - f0, bus.state); end
    endtask

    initial begin
        bus.tick = 1'b0; bus.btn_start = 1'b0; bus.btn_fly = 1'b0;
        bus.btn_pipe_up = 1'b0; bus.btn_pipe_down = 1'b0; bus.fail = 1'b0; bus.score = '0;
        test_reset();
        test_countdown();
        test_fly();
        test_pipe_random();
        test_pause();
        test_over();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
